// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state encoding for the bit-serial arithmetic blocks
package serial_arith_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit combinational full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder, LSB first, one bit per clock
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, sum_sr_q, sum_sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, busy_q, busy_d, done_q, done_d;
  logic fa_s, fa_co;
  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_co)
  );
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: if (start) begin
        a_sr_d   = a;
        b_sr_d   = b;
        carry_d  = cin;
        cnt_d    = '0;
        sum_sr_d = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        // shift form stays legal when WIDTH is 1
        sum_sr_d = (sum_sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        carry_d  = fa_co;
        cnt_d    = cnt_q + 1'b1;
        state_d  = (cnt_q == LAST) ? S_DONE : S_RUN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
    done_d = state_d == S_DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_sr_q;
  assign cout = carry_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (WIDTH 8 and 1)
module tb_serial_adder;
  logic clk = 0, rst = 1;
  logic start = 0, cin = 0, busy, done, cout;
  logic [7:0] a = 0, b = 0, sum;
  logic start1 = 0, a1 = 0, b1 = 0, cin1 = 0, busy1, done1, sum1, cout1;
  int errors = 0, checks = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );
  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [7:0] xa, xb, input logic xc, output int lat, output int busy_n);
    @(negedge clk);
    a = xa; b = xb; cin = xc; start = 1;
    @(negedge clk);
    start = 0; lat = 1; busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (busy) busy_n++;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++; $display("FAIL reset: busy=%b done=%b sum=%0d cout=%b, expected all 0", busy, done, sum, cout);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if ({busy1, done1, sum1, cout1} !== 4'd0) begin
      errors++; $display("FAIL reset_w1: busy=%b done=%b sum=%b cout=%b, expected all 0", busy1, done1, sum1, cout1);
    end
  endtask

  task automatic test_basic;
    int lat, bn;
    do_op(8'd100, 8'd55, 1'b0, lat, bn);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d expected 9", lat); end
    checks++;
    if (bn !== 9) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 9", bn); end
    checks++;
    if ({cout, sum} !== {1'b0, 8'd155}) begin
      errors++; $display("FAIL basic_sum: got cout=%b sum=%0d expected cout=0 sum=155", cout, sum);
    end
    @(negedge clk);
    checks++;
    if ({busy, done, cout, sum} !== {1'b0, 1'b0, 1'b0, 8'd155}) begin
      errors++; $display("FAIL basic_hold: busy=%b done=%b cout=%b sum=%0d expected 0 0 0 155", busy, done, cout, sum);
    end
  endtask

  task automatic test_carry;
    int lat, bn;
    do_op(8'd200, 8'd100, 1'b0, lat, bn);
    checks++;
    if ({cout, sum} !== {1'b1, 8'd44}) begin
      errors++; $display("FAIL carry_200_100: got cout=%b sum=%0d expected cout=1 sum=44", cout, sum);
    end
    do_op(8'hFF, 8'h00, 1'b1, lat, bn);
    checks++;
    if ({cout, sum} !== {1'b1, 8'd0}) begin
      errors++; $display("FAIL carry_ripple: got cout=%b sum=%0d expected cout=1 sum=0", cout, sum);
    end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL carry_latency: got %0d expected 9", lat); end
  endtask

  task automatic test_ignore;
    int pulses = 0, done_at = -1;
    logic [8:0] res = 0;
    @(negedge clk);
    a = 8'd10; b = 8'd20; cin = 1; start = 1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done) begin pulses++; done_at = n; res = {cout, sum}; end
      start = (n == 3 || n == 9);
      a = 8'hF0 + 8'(n); b = 8'hEE; cin = 0;
    end
    start = 0;
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
    checks++;
    if (done_at !== 9) begin errors++; $display("FAIL ignore_done_cycle: got %0d expected 9", done_at); end
    checks++;
    if (res !== 9'd31) begin errors++; $display("FAIL ignore_result: got %0d expected 31", res); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid;
    int lat, bn, seen = 0;
    @(negedge clk);
    a = 8'd77; b = 8'd99; cin = 1; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++; $display("FAIL reset_mid: busy=%b done=%b sum=%0d cout=%b expected all 0", busy, done, sum, cout);
    end
    repeat (3) begin @(negedge clk); if (done) seen++; end
    rst = 0;
    repeat (8) begin @(negedge clk); if (done || busy) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", seen); end
    do_op(8'd1, 8'd1, 1'b0, lat, bn);
    checks++;
    if ({cout, sum, lat} !== {1'b0, 8'd2, 32'd9}) begin
      errors++; $display("FAIL reset_mid_after: got cout=%b sum=%0d lat=%0d expected 0 2 9", cout, sum, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] xa [3] = '{8'd1, 8'd250, 8'd128};
    logic [7:0] xb [3] = '{8'd2, 8'd10, 8'd128};
    logic       xc [3] = '{1'b0, 1'b1, 1'b0};
    logic [8:0] exp_r [3] = '{9'd3, 9'd261, 9'd256};
    int k = 0, last = 0, n = 0;
    @(negedge clk);
    a = xa[0]; b = xb[0]; cin = xc[0]; start = 1;
    while (k < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (done) begin
        checks++;
        if ({cout, sum} !== exp_r[k]) begin
          errors++; $display("FAIL b2b_result%0d: got %0d expected %0d", k, {cout, sum}, exp_r[k]);
        end
        checks++;
        if (n - last !== (k == 0 ? 9 : 10)) begin
          errors++; $display("FAIL b2b_period%0d: got %0d expected %0d", k, n - last, k == 0 ? 9 : 10);
        end
        last = n;
        k++;
        if (k < 3) begin a = xa[k]; b = xb[k]; cin = xc[k]; end
        else start = 0;
      end
    end
    start = 0;
    checks++;
    if (k !== 3) begin errors++; $display("FAIL b2b_count: got %0d results expected 3", k); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_width1;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] t;
      v = 3'(i);
      t = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1;
      @(negedge clk);
      start1 = 0;
      checks++;
      if ({busy1, done1} !== 2'b10) begin
        errors++; $display("FAIL w1_run%0d: busy=%b done=%b expected 1 0", i, busy1, done1);
      end
      @(negedge clk);
      checks++;
      if ({done1, cout1, sum1} !== {1'b1, t}) begin
        errors++; $display("FAIL w1_result%0d: done=%b cout=%b sum=%b expected done=1 cout=%b sum=%b", i, done1, cout1, sum1, t[1], t[0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_ignore;
    test_reset_mid;
    test_back_to_back;
    test_width1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder. It accepts two operands and a carry-in on a start strobe, then adds one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. At the end it presents the sum, the carry-out and a one-cycle done pulse. It is the addition counterpart of the team's full-subtractor cell, and forms the sequential arithmetic building block in the basic-circuits library.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits; legal range is WIDTH ≥ 1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in; captured when start is accepted.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; sum and cout are valid.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

## Operation
- Internal state:
  - a_sr and b_sr: WIDTH-bit shift registers.
  - sum_sr: WIDTH-bit result shift register, driving the sum output.
  - carry flip-flop, driving the cout output.
  - bit counter cnt, $clog2(WIDTH+1) bits wide.
  - state register.
- IDLE, with start=1:
  - a_sr←a, b_sr←b, carry←cin, cnt←0, sum_sr←0.
  - Next state RUN.
- IDLE, with start=0: hold; sum and cout keep the last result.
- RUN, every cycle:
  - Full-adder inputs are a_sr[0], b_sr[0] and carry.
  - a_sr and b_sr shift right by one.
  - sum_sr←{s, sum_sr[WIDTH-1:1]}.
  - carry←co.
  - cnt←cnt+1.
  - When cnt==WIDTH-1, the update in that cycle is the last bit, and the next state is DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Next state IDLE unconditionally.
  - sum and cout hold.
- start while busy=1 (RUN or DONE) is ignored. It is not queued.
- a, b and cin changes after capture have no effect on the operation in progress.
- Arithmetic: the result is the unsigned sum. The sign of the operands is irrelevant; cout is the plain carry, not an overflow flag.
- The result stays held on sum/cout until the next accepted start clears sum_sr.

## Timing
- Reset (async assert, sampled deassert):
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - cnt, a_sr and b_sr are cleared.
- Reset asserted mid-RUN or in DONE aborts immediately; no done pulse is produced.
- Latency: start is accepted on edge E0. RUN occupies edges E1..E_WIDTH. done is high in the cycle after E_WIDTH, i.e. WIDTH+1 cycles after E0.
- busy rises the cycle after E0 and falls together with done (after edge E_WIDTH+1).
- Throughput: one operation per WIDTH+2 cycles. A start held high continuously is re-accepted in the first IDLE cycle after DONE.
- During RUN, sum shows partial results. It is only defined as final while done=1 and while idle afterwards.
- WIDTH=1: RUN lasts exactly one cycle, and done is high 2 cycles after acceptance.

## Structure
- Shared package serial_arith_pkg:
  - State encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - The same encodings are reused by the planned serial_subtractor.
  - Encoding 2'd3 is unreachable and recovers to IDLE.
- One sub-module, full_adder (a, b, cin → sum, cout). It is purely combinational and instantiated once for the bit-serial datapath.
- Everything else (FSM, counter, shift registers) lives in the top module.

## Test plan
- WIDTH=8; a=100, b=55, cin=0; start one cycle → done high exactly 9 cycles after acceptance; sum=155, cout=0; busy high for 9 cycles.
- a=200, b=100, cin=0 → sum=44, cout=1. Then a=8'hFF, b=0, cin=1 → sum=0, cout=1 (carry ripples through all bits).
- Start pulsed again at cycles 3 and 9 of an operation (RUN and DONE), with different operands → ignored; the result is from the first operands; exactly one done pulse.
- Assert rst at cycle 4 of RUN → busy, done, sum and cout are all 0 immediately. After release, a new start with a=1, b=1 → sum=2, cout=0.
- start held high permanently with operands changing every operation → accept, done, accept… at a period of WIDTH+2 = 10 cycles; each result matches the operands captured at its own acceptance.
- Sweep WIDTH=1 over all 8 {a,b,cin} combinations → sum/cout equal the full-adder truth table; done 2 cycles after each accept.
